// File: rtl/eater_control.sv
// eater_control: five T-state microcode sequencer for an 8-bit breadboard CPU.
// Build option EATER_FLAGS_EN adds the carry/zero flag register, fi, JC and JZ.
module eater_control #(
  parameter int STEPS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        alu_ovf,
  input  logic        alu_zf,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        cf,
  output logic        zf
);

  localparam logic [15:0] HLT = 16'h8000;
  localparam logic [15:0] MI  = 16'h4000;
  localparam logic [15:0] RI  = 16'h2000;
  localparam logic [15:0] RO  = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800;
  localparam logic [15:0] II  = 16'h0400;
  localparam logic [15:0] AI  = 16'h0200;
  localparam logic [15:0] AO  = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080;
  localparam logic [15:0] SU  = 16'h0040;
  localparam logic [15:0] BI  = 16'h0020;
  localparam logic [15:0] OI  = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008;
  localparam logic [15:0] CO  = 16'h0004;
  localparam logic [15:0] J   = 16'h0002;
`ifdef EATER_FLAGS_EN
  localparam logic [15:0] FI_EN = 16'h0001;
`else
  localparam logic [15:0] FI_EN = 16'h0000;
`endif

  // state | meaning
  // T0    | fetch: PC -> MAR
  // T1    | fetch: RAM -> IR, PC++
  // T2-T4 | opcode-specific execute steps
  // HALTED| frozen after HLT; only rst_n leaves
  typedef enum logic [2:0] {
    T0     = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    T3     = 3'd3,
    T4     = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam state_t LAST = state_t'(STEPS - 1);

  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == HALTED || ctrl[15]) state_d = HALTED;
    else if (state_q == LAST)          state_d = T0;
    else                               state_d = state_t'(state_q + 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= T0;
    else        state_q <= state_d;
  end

  // Halt reports T2 so the step display stays on the instruction that stopped us.
  assign step = (state_q == HALTED) ? 3'd2 : state_q;

  always_comb begin
    ctrl = 16'h0;
    case (state_q)
      T0:     ctrl = CO | MI;
      T1:     ctrl = RO | II | CE;
      HALTED: ctrl = HLT;
      default: begin
        case (opcode)
          4'h1: ctrl = (state_q == T2) ? (IO | MI) : (state_q == T3) ? (RO | AI) : 16'h0;
          4'h2: ctrl = (state_q == T2) ? (IO | MI) : (state_q == T3) ? (RO | BI)
                                                   : (EO | AI | FI_EN);
          4'h3: ctrl = (state_q == T2) ? (IO | MI) : (state_q == T3) ? (RO | BI)
                                                   : (EO | AI | SU | FI_EN);
          4'h4: ctrl = (state_q == T2) ? (IO | MI) : (state_q == T3) ? (AO | RI) : 16'h0;
          4'h5: ctrl = (state_q == T2) ? (IO | AI) : 16'h0;
          4'h6: ctrl = (state_q == T2) ? (IO | J) : 16'h0;
          4'h7: ctrl = (state_q == T2 && cf) ? (IO | J) : 16'h0;
          4'h8: ctrl = (state_q == T2 && zf) ? (IO | J) : 16'h0;
          4'hE: ctrl = (state_q == T2) ? (AO | OI) : 16'h0;
          4'hF: ctrl = (state_q == T2) ? HLT : 16'h0;
          default: ctrl = 16'h0;
        endcase
      end
    endcase
  end

`ifdef EATER_FLAGS_EN
  logic cf_q, zf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (ctrl[0]) begin
      cf_q <= alu_ovf;
      zf_q <= alu_zf;
    end
  end

  assign cf = cf_q;
  assign zf = zf_q;
`else
  logic unused_alu;
  assign unused_alu = alu_ovf ^ alu_zf;
  assign cf = 1'b0;
  assign zf = 1'b0;
`endif

endmodule
